// File: rtl/uart_pkg.sv
// Shared types and defaults for the stop-and-wait UART transmitter:
// FSM state encoding, ack byte and baud/timeout defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_ACK,
    RECV_ACK,
    CHECK
  } state_t;

  localparam logic [7:0] ACK_CODE_DEFAULT     = 8'hCC;
  localparam int         CLKS_PER_BIT_DEFAULT = 2604;  // 50 MHz / 19200 baud
  localparam int         ACK_TIMEOUT_DEFAULT  = 300;

  // Ack frame slots: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  localparam logic [3:0] RX_START_IDX = 4'd0;
  localparam logic [3:0] RX_STOP_IDX  = 4'd9;

endpackage

// File: rtl/uart_baud_ctr.sv
// Bit-period counter: bit_tick on the last cycle of each bit, mid_tick
// half a bit after a restart so the receiver samples mid-bit.
module uart_baud_ctr #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic bit_tick,
  output logic mid_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  // The cycle that saw the edge counts as position 0, so this lands at CLKS_PER_BIT/2.
  localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_tick = en && !restart && (cnt == LAST);
  assign mid_tick = en && !restart && (cnt == MID);

endmodule

// File: rtl/uart_arq_tx.sv
// UART transmitter with stop-and-wait ARQ: sends one frame, waits for an
// ack byte on ack_rx and retransmits on timeout or a bad reply.
module uart_arq_tx
  import uart_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int         PARITY_EN    = 0,
  parameter int         MSB_FIRST    = 1,
  parameter int         MAX_RETRY    = 5,
  parameter int         ACK_TIMEOUT  = ACK_TIMEOUT_DEFAULT,
  parameter logic [7:0] ACK_CODE     = ACK_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              ack_rx,
  output logic              tx_serial,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [3:0]        retry_cnt
);

  localparam int               TO_W       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]       LAST_BIT   = 4'(DATA_W - 1);
  localparam logic [3:0]       RETRY_LIM  = 4'(MAX_RETRY);

  state_t            state;
  logic [DATA_W-1:0] data_q;     // payload, already in wire order
  logic [DATA_W-1:0] tx_shift;   // next data bit always at the top
  logic [3:0]        bit_idx;
  logic [3:0]        rx_idx;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        rx_byte;
  logic              stop_q;
  logic              got_frame;
  logic [1:0]        ack_meta;
  logic              ack_sync;
  logic              restart;
  logic              en;
  logic              bit_tick;
  logic              mid_tick;

  // Reorder once at load time so the shifter only ever sends its top bit.
  function automatic logic [DATA_W-1:0] orient(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return (MSB_FIRST != 0) ? d : r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack_meta <= 2'b11;
    else       ack_meta <= {ack_meta[0], ack_rx};
  end
  assign ack_sync = ack_meta[1];

  // NOTE: always_comb gives every output a default first so no latch is inferred.
  always_comb begin
    restart = 1'b0;
    if (state == IDLE || state == CHECK)          restart = 1'b1;
    if (state == WAIT_ACK && !ack_sync)           restart = 1'b1;
  end
  assign en = (state != IDLE);

  uart_baud_ctr #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .en       (en),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      data_q    <= '0;
      tx_shift  <= '0;
      bit_idx   <= '0;
      rx_idx    <= '0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      stop_q    <= 1'b0;
      got_frame <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            data_q    <= orient(tx_data);
            tx_shift  <= orient(tx_data);
            retry_cnt <= '0;
            fail      <= 1'b0;
            busy      <= 1'b1;
            tx_ready  <= 1'b0;
            tx_serial <= 1'b0;
            state     <= START;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (bit_tick) begin
            tx_serial <= tx_shift[DATA_W-1];
            tx_shift  <= tx_shift << 1;
            bit_idx   <= '0;
            state     <= DATA;
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx_serial <= ^data_q;
                state     <= PARITY;
              end else begin
                tx_serial <= 1'b1;
                state     <= STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= tx_shift[DATA_W-1];
              tx_shift  <= tx_shift << 1;
            end
          end
        end

        PARITY: begin
          if (bit_tick) begin
            tx_serial <= 1'b1;
            state     <= STOP;
          end
        end

        STOP: begin
          if (bit_tick) begin
            to_cnt    <= '0;
            got_frame <= 1'b0;
            state     <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (!ack_sync) begin
            rx_idx <= RX_START_IDX;
            state  <= RECV_ACK;
          end else if (bit_tick) begin
            if (to_cnt == TO_LAST) begin
              got_frame <= 1'b0;
              state     <= CHECK;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end

        RECV_ACK: begin
          if (mid_tick) begin
            if (rx_idx == RX_START_IDX) begin
              // A start bit that is high again at mid-bit was only a glitch.
              if (ack_sync) state  <= WAIT_ACK;
              else          rx_idx <= rx_idx + 1'b1;
            end else if (rx_idx == RX_STOP_IDX) begin
              stop_q    <= ack_sync;
              got_frame <= 1'b1;
              state     <= CHECK;
            end else begin
              rx_byte <= {rx_byte[6:0], ack_sync};
              rx_idx  <= rx_idx + 1'b1;
            end
          end
        end

        CHECK: begin
          if (got_frame && stop_q && rx_byte == ACK_CODE) begin
            done  <= 1'b1;
            fail  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (retry_cnt < RETRY_LIM) begin
            retry_cnt <= retry_cnt + 1'b1;
            tx_shift  <= data_q;
            tx_serial <= 1'b0;
            state     <= START;
          end else begin
            done  <= 1'b1;
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_arq_tx.sv
// Directed bench for uart_arq_tx: one instance without parity, one with,
// both at 4 clocks per bit, 20 bit-time ack timeout and 2 retries.
module tb_uart_arq_tx;

  localparam int CPB     = 4;
  localparam int TIMEOUT = 20;
  localparam int RETRIES = 2;
  localparam int IDLE_GAP = TIMEOUT * CPB + 1;  // WAIT_ACK bit-times plus the CHECK cycle

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic [1:0] tx_valid_w;
  logic [1:0] ack_w;
  logic [1:0] tx_ready_w;
  logic [1:0] tx_serial_w;
  logic [1:0] busy_w;
  logic [1:0] done_w;
  logic [1:0] fail_w;
  logic [3:0] retry_w [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_arq_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .MSB_FIRST(1),
                .MAX_RETRY(RETRIES), .ACK_TIMEOUT(TIMEOUT), .ACK_CODE(8'hCC)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_w[0]), .tx_data(tx_data),
    .tx_ready(tx_ready_w[0]), .ack_rx(ack_w[0]), .tx_serial(tx_serial_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .fail(fail_w[0]), .retry_cnt(retry_w[0]));

  uart_arq_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .MSB_FIRST(1),
                .MAX_RETRY(RETRIES), .ACK_TIMEOUT(TIMEOUT), .ACK_CODE(8'hCC)) dut_par (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_w[1]), .tx_data(tx_data),
    .tx_ready(tx_ready_w[1]), .ack_rx(ack_w[1]), .tx_serial(tx_serial_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .fail(fail_w[1]), .retry_cnt(retry_w[1]));

  typedef struct {
    logic        sel;        // 0: no parity, 1: parity instance
    logic [7:0]  data;
    int          nbits;      // frame length in bits
    logic [10:0] frame;      // first bit on the wire at frame[nbits-1]
    logic        acked;      // 1: reply 8'hCC after 3 bit-times, 0: stay silent
    logic        exp_fail;
    logic [3:0]  exp_retry;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
  endtask

  // Called right after a falling edge; returns at the falling edge of START cycle 0.
  task automatic send(input logic sel, input logic [7:0] d);
    check("ready_before_send", 32'(tx_ready_w[sel]), 32'd1);
    tx_data         = d;
    tx_valid_w[sel] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid_w[sel] = 1'b0;
    tx_data         = ~d;   // must not leak into the frame
    @(negedge clk);
    check("busy_after_accept", 32'(busy_w[sel]), 32'd1);
    check("ready_after_accept", 32'(tx_ready_w[sel]), 32'd0);
  endtask

  task automatic capture_frame(input logic sel, input int nbits,
                               output logic [10:0] got, output logic stable);
    logic s;
    got    = '0;
    stable = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        s = tx_serial_w[sel];
        if (c == 0) got = {got[9:0], s};
        else if (s !== got[0]) stable = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic count_high(input logic sel, output int n);
    n = 0;
    while (tx_serial_w[sel] === 1'b1 && done_w[sel] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input logic sel, output int n);
    n = 0;
    while (done_w[sel] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic reply(input logic sel, input logic [7:0] b, input int delay_bits);
    logic [9:0] f;
    f = {1'b0, b, 1'b1};
    repeat (delay_bits * CPB) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      ack_w[sel] = f[9];
      f          = f << 1;
      repeat (CPB) @(negedge clk);
    end
    ack_w[sel] = 1'b1;
  endtask

  // Called at the falling edge where done should be high.
  task automatic finish_checks(input logic sel, input logic exp_fail, input logic [3:0] exp_retry);
    check("done_seen", 32'(done_w[sel]), 32'd1);
    check("fail", 32'(fail_w[sel]), 32'(exp_fail));
    check("retry_cnt", 32'(retry_w[sel]), 32'(exp_retry));
    check("ready_low_on_done", 32'(tx_ready_w[sel]), 32'd0);
    check("busy_low_on_done", 32'(busy_w[sel]), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done_w[sel]), 32'd0);
    check("ready_after_done", 32'(tx_ready_w[sel]), 32'd1);
  endtask

  task automatic run_vector(input vec_t v);
    logic [10:0] got;
    logic        stable;
    int          attempts;
    int          n;
    attempts = v.acked ? 1 : RETRIES + 1;
    send(v.sel, v.data);
    for (int a = 0; a < attempts; a++) begin
      capture_frame(v.sel, v.nbits, got, stable);
      check("frame_bits", 32'(got), 32'(v.frame));
      check("frame_bit_width", 32'(stable), 32'd1);
      if (a < attempts - 1) begin
        count_high(v.sel, n);
        check("timeout_gap", 32'(n), 32'(IDLE_GAP));
      end
    end
    if (v.acked) begin
      fork
        reply(v.sel, 8'hCC, 3);
        wait_done(v.sel, n);
      join
    end else begin
      wait_done(v.sel, n);
      check("final_timeout_gap", 32'(n), 32'(IDLE_GAP));
    end
    finish_checks(v.sel, v.exp_fail, v.exp_retry);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got;
    logic        stable;
    int          n;
    int          done_seen;

    vecs[0] = '{1'b0, 8'hA5, 10, 11'b00101001011, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 8'h3C, 10, 11'b00001111001, 1'b0, 1'b1, 4'd2};
    vecs[2] = '{1'b1, 8'h07, 11, 11'b00000011111, 1'b1, 1'b0, 4'd0};
    vecs[3] = '{1'b0, 8'h00, 10, 11'b00000000001, 1'b1, 1'b0, 4'd0};
    vecs[4] = '{1'b1, 8'hFF, 11, 11'b01111111101, 1'b1, 1'b0, 4'd0};

    reset      = 1'b1;
    tx_data    = '0;
    tx_valid_w = '0;
    ack_w      = 2'b11;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_tx_serial", 32'(tx_serial_w[s]), 32'd1);
      check("rst_tx_ready", 32'(tx_ready_w[s]), 32'd1);
      check("rst_busy", 32'(busy_w[s]), 32'd0);
      check("rst_done", 32'(done_w[s]), 32'd0);
      check("rst_fail", 32'(fail_w[s]), 32'd0);
      check("rst_retry_cnt", 32'(retry_w[s]), 32'd0);
    end

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Bad reply 8'h33 forces exactly one retransmission, then 8'hCC acks.
    send(1'b0, 8'h96);
    capture_frame(1'b0, 10, got, stable);
    check("retry_frame1", 32'(got), 32'(11'b00100101101));
    fork
      reply(1'b0, 8'h33, 3);
      count_high(1'b0, n);
    join
    check("retry_restarted", 32'(tx_serial_w[0]), 32'd0);
    check("retry_cnt_mid", 32'(retry_w[0]), 32'd1);
    capture_frame(1'b0, 10, got, stable);
    check("retry_frame2", 32'(got), 32'(11'b00100101101));
    check("retry_frame2_width", 32'(stable), 32'd1);
    fork
      reply(1'b0, 8'hCC, 3);
      wait_done(1'b0, n);
    join
    finish_checks(1'b0, 1'b0, 4'd1);

    // A one-cycle low glitch in WAIT_ACK must not be taken as a reply.
    send(1'b1, 8'h07);
    capture_frame(1'b1, 11, got, stable);
    check("glitch_frame", 32'(got), 32'(11'b00000011111));
    fork
      begin
        repeat (8) @(negedge clk);
        ack_w[1] = 1'b0;
        @(negedge clk);
        ack_w[1] = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_no_resend", 32'(tx_serial_w[1]), 32'd1);
        reply(1'b1, 8'hCC, 0);
      end
      wait_done(1'b1, n);
    join
    finish_checks(1'b1, 1'b0, 4'd0);

    // Reset in the middle of the data bits drops the transfer silently.
    send(1'b0, 8'hA5);
    repeat (9) @(negedge clk);
    check("pre_reset_low_bit", 32'(tx_serial_w[0]), 32'd0);
    reset = 1'b1;
    #1;
    check("reset_tx_serial", 32'(tx_serial_w[0]), 32'd1);
    check("reset_busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_w[0] === 1'b1) done_seen++;
      @(negedge clk);
    end
    check("no_done_after_reset", 32'(done_seen), 32'd0);
    check("idle_line_after_reset", 32'(tx_serial_w[0]), 32'd1);
    run_vector(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_arq_tx.md
UART_ARQ_TX -- requirements
Module: uart_arq_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame, 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 2604: clk cycles per bit (50 MHz / 19200 baud), minimum 4.
REQ-003 Parameter PARITY_EN, default 0: 1 appends an even-parity bit after the data bits.
REQ-004 Parameter MSB_FIRST, default 1: 1 sends data MSB first, 0 sends LSB first.
REQ-005 Parameter MAX_RETRY, default 5: retransmissions after the first attempt, 0..15.
REQ-006 Parameter ACK_TIMEOUT, default 300: bit-times to wait for an ack start bit.
REQ-007 Parameter ACK_CODE, default 8'hCC: ack byte, received MSB first.
REQ-008 Port clk, input, 1: the only clock; all logic is clocked on its rising edge.
REQ-009 Port reset, input, 1: asynchronous, active-high reset.
REQ-010 Port tx_valid, input, 1: request to send tx_data.
REQ-011 Port tx_data, input, DATA_W: payload.
REQ-012 Port tx_ready, output, 1: high in IDLE only; a transfer is accepted when tx_valid and tx_ready are high on the same edge.
REQ-013 Port ack_rx, input, 1: serial ack line, idle high; two-flop synchronised inside the block.
REQ-014 Port tx_serial, output, 1: serial line, idle high.
REQ-015 Port busy, output, 1: high from acceptance until the done pulse.
REQ-016 Port done, output, 1: one-cycle pulse when a transfer ends.
REQ-017 Port fail, output, 1: valid with done; 1 = retries exhausted.
REQ-018 Port retry_cnt, output, 4: retransmissions used by the current or last transfer.

Function
REQ-019 States: IDLE, START, DATA, PARITY, STOP, WAIT_ACK, RECV_ACK, CHECK.
REQ-020 On acceptance, the block latches tx_data, clears retry_cnt and enters START on the next cycle; tx_data changes after acceptance have no effect.
REQ-021 START, DATA (DATA_W bits), PARITY (only if PARITY_EN) and STOP (high) each drive tx_serial for exactly CLKS_PER_BIT cycles; the baud counter restarts at START.
REQ-022 Parity bit = XOR of the DATA_W payload bits (even parity).
REQ-023 WAIT_ACK holds tx_serial high and counts bit-times; a synchronised 0 on ack_rx enters RECV_ACK; reaching ACK_TIMEOUT with no start bit enters CHECK as a NAK.
REQ-024 RECV_ACK realigns the baud counter to the start edge; it samples the start bit, 8 data bits and the stop bit at mid-bit (CLKS_PER_BIT/2).
REQ-025 A start sample of 1 is a glitch: the block returns to WAIT_ACK and the timeout count continues.
REQ-026 CHECK: the received byte equals ACK_CODE and the stop bit is 1 -> done=1, fail=0, go to IDLE.
REQ-027 CHECK: otherwise, if retry_cnt < MAX_RETRY -> retry_cnt+1, resend the latched data from START; else done=1, fail=1, go to IDLE.
REQ-028 ack_rx activity outside WAIT_ACK and RECV_ACK is ignored.
REQ-029 tx_ready is 0 in the cycle done pulses; a new request is accepted no earlier than the following cycle.
REQ-030 With MAX_RETRY=0 the block makes exactly one attempt.

Reset
REQ-031 Asserting reset at any time forces IDLE immediately.
REQ-032 Reset values: tx_serial=1, tx_ready=1 after release, busy=0, done=0, fail=0, retry_cnt=0, all counters 0.
REQ-033 A transfer interrupted by reset is dropped with no done pulse.

Structure
REQ-034 Package uart_pkg holds the state encoding, ACK_CODE default and baud constants.
REQ-035 Sub-module uart_baud_ctr (params CLKS_PER_BIT; inputs restart, en; outputs bit_tick, mid_tick) is instantiated once.

Verification (CLKS_PER_BIT=4, ACK_TIMEOUT=20, MAX_RETRY=2)
REQ-036 Send 8'hA5, ACK_CODE returned after 3 bit-times -> tx_serial 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; done=1, fail=0, retry_cnt=0.
REQ-037 Send 8'h3C, no ack -> 3 identical frames, each followed by 20 bit-times of waiting; then done=1, fail=1, retry_cnt=2.
REQ-038 Reply 8'h33, then 8'hCC -> exactly one retransmission; done=1, fail=0, retry_cnt=1.
REQ-039 PARITY_EN=1, send 8'h07 -> parity bit 1 after the data bits; a 1-cycle low glitch on ack_rx in WAIT_ACK does not start reception.
REQ-040 Assert reset mid-DATA -> tx_serial=1 and busy=0 immediately; no done pulse; the next request is accepted normally.
